mem_port_arbiter: RTL

Shares one single-port unified memory between the pipeline's instruction-fetch requester (IF) and the data-access requester (MEM stage). Arbitrates, sequences one memory transaction at a time, returns read data with a one-cycle valid pulse, and produces stall signals for the hazard unit. Sits between the CPU core and the memory inside the top-level computer.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters with stalls and timeout
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          bus_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          m_req_q, m_req_d, m_we_q, m_we_d, i_valid_q, i_valid_d, d_valid_q, d_valid_d;
    logic          bus_err_q, bus_err_d, i_blk_q, i_blk_d, d_blk_q, d_blk_d;
    logic [3:0]    m_be_q, m_be_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic          busy, done, tout, arb, i_el, d_el, g_i, g_d;
    always_comb begin
        busy      = state_q != IDLE;
        done      = busy & m_ready;
        tout      = busy & ~m_ready & (tmo_q == TW'(TIMEOUT - 1));
        arb       = ~busy | done;
        i_el      = arb & i_req & ~i_blk_q & (state_q != IBUSY);
        d_el      = arb & d_req & ~d_blk_q & (state_q != DBUSY);
        g_i       = i_el & (~d_el | (starve_q == SW'(STARVE_LIMIT)));
        g_d       = d_el & ~g_i;
        state_d   = g_i ? IBUSY : g_d ? DBUSY : (arb | tout) ? IDLE : state_q;
        m_req_d   = g_i | g_d | (m_req_q & ~arb & ~tout);
        m_we_d    = g_d ? d_we : g_i ? 1'b0 : m_we_q;
        m_be_d    = g_d ? d_be : g_i ? 4'hF : m_be_q;
        m_addr_d  = g_d ? d_addr : g_i ? i_addr : m_addr_q;
        m_wdata_d = g_d ? d_wdata : m_wdata_q;
        i_valid_d = done & (state_q == IBUSY);
        d_valid_d = done & (state_q == DBUSY);
        i_rdata_d = i_valid_d ? m_rdata : i_rdata_q;
        d_rdata_d = (d_valid_d & ~m_we_q) ? m_rdata : d_rdata_q;
        starve_d  = (~i_req | g_i) ? '0 : (g_d & (starve_q != SW'(STARVE_LIMIT))) ? starve_q + 1'b1 : starve_q;
        tmo_d     = (g_i | g_d) ? '0 : (busy & ~m_ready) ? tmo_q + 1'b1 : tmo_q;
        bus_err_d = bus_err_q | tout;
        i_blk_d   = i_req & (i_blk_q | (tout & (state_q == IBUSY)));
        d_blk_d   = d_req & (d_blk_q | (tout & (state_q == DBUSY)));
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            tmo_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            bus_err_q <= 1'b0;
            i_blk_q   <= 1'b0;
            d_blk_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            bus_err_q <= bus_err_d;
            i_blk_q   <= i_blk_d;
            d_blk_q   <= d_blk_d;
        end
    end
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign bus_err = bus_err_q;
    assign i_stall = i_req & ~i_valid_q;
    assign d_stall = d_req & ~d_valid_q;
endmodule
